// File: rtl/hevc_interp_pkg.sv
// Shared constants and FSM encoding for the reference block loader.
package hevc_interp_pkg;

    localparam int BLK_DIM = 15;
    localparam int PIX_W   = 8;
    localparam int ROW_W   = 120;
    localparam int BLK_PIX = 225;

    localparam logic [3:0] LAST_IDX = 4'(BLK_DIM - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SERVE = 2'd1,
        STALL = 2'd2
    } loader_state_t;

endpackage

// File: rtl/ref_block_loader_row_bank.sv
// 15x120-bit register file with a byte-write port and a combinational row read.
module row_bank
    import hevc_interp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       wr_row,
    input  logic [3:0]       wr_col,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [3:0]       rd_row,
    output logic [ROW_W-1:0] rd_data
);

    logic [ROW_W-1:0] mem [BLK_DIM];

    // Clear every row on reset; otherwise write one pixel byte into its column slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BLK_DIM; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wr_row <= LAST_IDX) && (wr_col <= LAST_IDX)) begin
            mem[wr_row][{wr_col, 3'b000} +: PIX_W] <= wr_data;
        end
    end

    // Rows beyond the block read back as zero.
    always_comb begin
        rd_data = '0;
        if (rd_row <= LAST_IDX) begin
            rd_data = mem[rd_row];
        end
    end

endmodule

// File: rtl/ref_block_loader.sv
// Double-buffered 15x15 reference block loader: one bank fills from the
// pixel stream while the other serves rows to the interpolator.
module ref_block_loader
    import hevc_interp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    input  logic [3:0]       next_row,
    output logic [ROW_W-1:0] in_row,
    output logic             blk_valid,
    input  logic             blk_release,
    output logic [7:0]       fill_cnt
);

    loader_state_t state, state_nx;
    logic          bank_sel, bank_sel_nx;
    logic [7:0]    fill_nx;
    logic [3:0]    row, row_nx;
    logic [3:0]    col, col_nx;
    logic          accept;
    logic          last_pix;
    logic          release_ok;
    logic [ROW_W-1:0] rd0, rd1;

    // bank_sel names the fill bank; the other bank is the serving bank.
    row_bank u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we      (accept && !bank_sel),
        .wr_row  (row),
        .wr_col  (col),
        .wr_data (pix_data),
        .rd_row  (next_row),
        .rd_data (rd0)
    );

    row_bank u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we      (accept && bank_sel),
        .wr_row  (row),
        .wr_col  (col),
        .wr_data (pix_data),
        .rd_row  (next_row),
        .rd_data (rd1)
    );

    // Handshake and served-row outputs; reset forces pix_ready low.
    always_comb begin
        pix_ready  = rst && (state != STALL);
        blk_valid  = (state != EMPTY);
        accept     = pix_valid && pix_ready;
        last_pix   = accept && (row == LAST_IDX) && (col == LAST_IDX);
        release_ok = blk_release && blk_valid;
        in_row     = '0;
        if (blk_valid) begin
            in_row = bank_sel ? rd0 : rd1;
        end
    end

    // Next-state logic: raster counters, bank swap and fill count.
    always_comb begin
        state_nx    = state;
        bank_sel_nx = bank_sel;
        fill_nx     = fill_cnt;
        row_nx      = row;
        col_nx      = col;

        if (accept) begin
            fill_nx = fill_cnt + 8'd1;
            if (col == LAST_IDX) begin
                col_nx = 4'd0;
                row_nx = row + 4'd1;
            end else begin
                col_nx = col + 4'd1;
            end
        end
        if (last_pix) begin
            row_nx = 4'd0;
            col_nx = 4'd0;
        end

        case (state)
            EMPTY: begin
                if (last_pix) begin
                    state_nx    = SERVE;
                    bank_sel_nx = ~bank_sel;
                    fill_nx     = 8'd0;
                end
            end
            SERVE: begin
                if (last_pix && release_ok) begin
                    bank_sel_nx = ~bank_sel;
                    fill_nx     = 8'd0;
                end else if (last_pix) begin
                    state_nx = STALL;
                end else if (release_ok) begin
                    state_nx = EMPTY;
                end
            end
            STALL: begin
                if (release_ok) begin
                    state_nx    = SERVE;
                    bank_sel_nx = ~bank_sel;
                    fill_nx     = 8'd0;
                end
            end
            default: begin
                state_nx = EMPTY;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            bank_sel <= 1'b0;
            fill_cnt <= 8'd0;
            row      <= 4'd0;
            col      <= 4'd0;
        end else begin
            state    <= state_nx;
            bank_sel <= bank_sel_nx;
            fill_cnt <= fill_nx;
            row      <= row_nx;
            col      <= col_nx;
        end
    end

endmodule

// File: doc/ref_block_loader.md
REF_BLOCK_LOADER -- requirements
Module: ref_block_loader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, using the port names clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset; block held in reset while low.
REQ-004 pix_valid  input  1  pixel stream has data this cycle.
REQ-005 pix_data  input  8  pixel, raster order (row 0 col 0 first).
REQ-006 pix_ready  output  1  loader accepts a pixel this cycle.
REQ-007 next_row  input  4  row index requested by the interpolator.
REQ-008 in_row  output  120  requested row of the serving bank, 15 pixels.
REQ-009 blk_valid  output  1  serving bank holds a complete 15x15 block.
REQ-010 blk_release  input  1  single-cycle pulse; interpolator is done with the serving block.
REQ-011 fill_cnt  output  8  pixels accepted into the fill bank, 0..225.

Function
REQ-012 SHALL accept a pixel exactly on cycles where pix_valid and pix_ready are both high.
REQ-013 SHALL hold two 15x120-bit banks; one is the fill bank, the other the serving bank.
REQ-014 SHALL write each accepted pixel at fill-bank row r, col c, bits [8c+7:8c]; column counter wraps 14->0 and increments the row counter, with no division.
REQ-015 SHALL drive in_row combinationally (zero latency) from serving bank row next_row, and 0 when next_row > 14 or blk_valid = 0.
REQ-016 SHALL implement FSM states EMPTY (no block served), SERVE (serving, filling other bank), STALL (serving, fill bank full).
REQ-017 EMPTY: on the 225th accept -> SERVE, swap banks, set blk_valid=1, clear fill_cnt.
REQ-018 SERVE: 225th accept without blk_release -> STALL; 225th accept with blk_release in the same cycle -> stay SERVE with swap and fill_cnt cleared; blk_release alone -> EMPTY, partial fill retained.
REQ-019 STALL: blk_release -> SERVE, swap, clear fill_cnt; pix_ready SHALL be 0 throughout STALL.
REQ-020 pix_ready SHALL be 1 in EMPTY and SERVE and 0 in STALL and during reset.
REQ-021 blk_release while blk_valid=0 SHALL be ignored.
REQ-022 A swap SHALL take effect at the clock edge; in_row reflects the new bank in the following cycle.
REQ-023 fill_cnt SHALL never exceed 225; the 225th accept updates state/swap, not fill_cnt=225, except in STALL where fill_cnt reads 225.

Reset
REQ-024 On rst low: state EMPTY, bank select 0, fill_cnt 0, row/col counters 0, blk_valid 0, pix_ready 0, in_row 0, both banks cleared to 0.
REQ-025 Reset mid-load or mid-serve SHALL discard all partial and complete blocks; a full 225-pixel block is required afterwards.

Structure
REQ-026 Shared package hevc_interp_pkg SHALL hold BLK_DIM=15, PIX_W=8, ROW_W=120, BLK_PIX=225 and the FSM state encoding.
REQ-027 SHALL instantiate a sub-module row_bank twice; each row_bank is a 15x120 register file with a byte-write port (row, col, data, we) and one combinational 120-bit read port.

Verification
REQ-028 Reset, stream 225 pixels with value = index mod 256, next_row=0 -> blk_valid rises 1 cycle after the last accept; in_row = 0x0e0d0c0b0a09080706050403020100.
REQ-029 Serving block 1 with next_row=15 -> in_row = 0; next_row=14 -> in_row holds pixels 0xd2..0xe0, with 0xd2 at [7:0].
REQ-030 Stream a second 225-pixel block (value 0xA5) while serving -> pix_ready falls after the last accept, in_row unchanged; pulse blk_release -> next cycle in_row = all 0xA5 and pix_ready=1.
REQ-031 blk_release coincident with the 225th accept -> no STALL cycle; pix_ready stays 1; swap visible the next cycle.
REQ-032 Random pix_valid gaps (50%) -> identical bank contents to the gap-free run.
REQ-033 Assert rst after 100 accepts -> fill_cnt=0, blk_valid=0; a subsequent 224 pixels leave blk_valid=0, and the 225th sets it.
